// File: rtl/rom_load_pkg.sv
// rom_load_pkg: shared state type, default sizing and region indices for the ROM download sequencer
package rom_load_pkg;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_REG_SEL_W = 2;
  localparam int DEF_HOLD_CYCLES = 16;
  localparam int REG_PROG = 0;
  localparam int REG_SPRITE = 1;
  localparam int REG_PLAYFIELD = 2;
  localparam int REG_SYNC = 3;
  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, HOLD, RUN} state_t;
endpackage

// File: rtl/rom_wr_skid.sv
// rom_wr_skid: single-entry region write buffer with valid/ready, capture and drop detection
module rom_wr_skid
  import rom_load_pkg::*;
#(
  parameter int SEL_W = DEF_REG_SEL_W,
  parameter int OFS_W = DEF_ADDR_W - DEF_REG_SEL_W,
  localparam int N = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [SEL_W-1:0] sel,
  input  logic [OFS_W-1:0] ofs,
  input  logic [7:0]       din,
  input  logic [N-1:0]     ready,
  output logic [N-1:0]     we,
  output logic [OFS_W-1:0] addr,
  output logic [7:0]       data,
  output logic             cap,
  output logic             drop,
  output logic             pending
);
  logic accept;
  always_comb begin
    pending = |we;
    accept = |(we & ready);
    cap = wr & (~pending | accept);
    drop = wr & pending & ~accept;
  end
  // a capture in the accept cycle replaces the old write with no bubble
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      we <= '0;
      addr <= '0;
      data <= '0;
    end else begin
      we <= cap ? N'(1) << sel : accept ? '0 : we;
      if (cap) begin
        addr <= ofs;
        data <= din;
      end
    end
endmodule

// File: rtl/rom_load_ctrl.sv
// rom_load_ctrl: sequences the HPS ROM download into core ROM regions and holds the core in reset around it
module rom_load_ctrl
  import rom_load_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int REG_SEL_W = DEF_REG_SEL_W,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  localparam int NUM_REGIONS = 2 ** REG_SEL_W
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic                      ioctl_download,
  input  logic                      ioctl_wr,
  input  logic [ADDR_W-1:0]         ioctl_addr,
  input  logic [7:0]                ioctl_dout,
  input  logic [NUM_REGIONS-1:0]    rom_ready,
  output logic [NUM_REGIONS-1:0]    rom_we,
  output logic [ADDR_W-REG_SEL_W-1:0] rom_addr,
  output logic [7:0]                rom_data,
  output logic                      core_reset_n,
  output logic                      load_done,
  output logic [ADDR_W:0]           byte_count,
  output logic [7:0]                checksum,
  output logic                      overflow
);
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic loaded, dl_q, rise, cap, drop, pending;
  rom_wr_skid #(.SEL_W(REG_SEL_W), .OFS_W(ADDR_W - REG_SEL_W)) u_skid (
    .clk(clk_sys),
    .rst(reset),
    .wr(ioctl_wr && state == LOAD),
    .sel(ioctl_addr[ADDR_W-1 -: REG_SEL_W]),
    .ofs(ioctl_addr[ADDR_W-REG_SEL_W-1:0]),
    .din(ioctl_dout),
    .ready(rom_ready),
    .we(rom_we),
    .addr(rom_addr),
    .data(rom_data),
    .cap(cap),
    .drop(drop),
    .pending(pending)
  );
  always_comb begin
    rise = ioctl_download & ~dl_q;
    state_n = rise ? LOAD :
              (state == LOAD && !ioctl_download) ? DRAIN :
              (state == DRAIN && !pending) ? HOLD :
              (state == HOLD && cnt == CNT_W'(1)) ? RUN : state;
    core_reset_n = state == RUN;
    load_done = core_reset_n & loaded;
  end
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      state <= HOLD;
      cnt <= CNT_W'(HOLD_CYCLES);
      loaded <= 1'b0;
      dl_q <= 1'b0;
      byte_count <= '0;
      checksum <= '0;
      overflow <= 1'b0;
    end else begin
      dl_q <= ioctl_download;
      state <= state_n;
      cnt <= state == DRAIN ? CNT_W'(HOLD_CYCLES) : state == HOLD ? cnt - CNT_W'(1) : cnt;
      loaded <= rise | (loaded & ~core_reset_n);
      if (rise) begin
        byte_count <= '0;
        checksum <= '0;
        overflow <= 1'b0;
      end else begin
        if (cap && !(&byte_count)) byte_count <= byte_count + (ADDR_W + 1)'(1);
        if (cap) checksum <= checksum + ioctl_dout;
        if (drop) overflow <= 1'b1;
      end
    end
endmodule

// File: tb/tb_rom_load_ctrl.sv
// tb_rom_load_ctrl: directed self-checking bench for the ROM download sequencer
module tb_rom_load_ctrl;
  logic clk_sys = 1'b0, reset = 1'b1, ioctl_download = 1'b0, ioctl_wr = 1'b0;
  logic [15:0] ioctl_addr = '0;
  logic [7:0] ioctl_dout = '0;
  logic [3:0] rom_ready = '0;
  logic [3:0] rom_we;
  logic [13:0] rom_addr;
  logic [7:0] rom_data, checksum;
  logic core_reset_n, load_done, overflow;
  logic [16:0] byte_count;
  int errors = 0, checks = 0;

  always #5 clk_sys = ~clk_sys;

  rom_load_ctrl dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .rom_ready(rom_ready), .rom_we(rom_we),
    .rom_addr(rom_addr), .rom_data(rom_data), .core_reset_n(core_reset_n), .load_done(load_done),
    .byte_count(byte_count), .checksum(checksum), .overflow(overflow)
  );

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // counts edges until the core leaves reset (bounded), plus load_done pulses seen on the way and shortly after
  task automatic wait_run(output int n, output int pulses);
    n = 0;
    pulses = 0;
    while (!core_reset_n && n < 200) begin
      tick();
      n++;
      pulses += int'(load_done);
    end
    repeat (3) begin
      tick();
      pulses += int'(load_done);
    end
  endtask

  task automatic test_reset();
    int n, p;
    #12;
    checks++; if (rom_we !== 4'b0000) begin errors++; $display("FAIL rst_we: got %b expected 0000", rom_we); end
    checks++; if (core_reset_n !== 1'b0) begin errors++; $display("FAIL rst_core_reset_n: got %b expected 0", core_reset_n); end
    checks++; if ({load_done, overflow, byte_count, checksum, rom_addr, rom_data} !== '0) begin
      errors++; $display("FAIL rst_outputs: got done=%b ovf=%b cnt=%0h sum=%0h addr=%0h data=%0h expected all 0",
                         load_done, overflow, byte_count, checksum, rom_addr, rom_data);
    end
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
    wait_run(n, p);
    checks++; if (n !== 16) begin errors++; $display("FAIL rst_hold_len: got %0d expected 16", n); end
    checks++; if (p !== 0) begin errors++; $display("FAIL rst_no_done: got %0d pulses expected 0", p); end
  endtask

  task automatic test_load();
    logic [15:0] a[4] = '{16'h0000, 16'h4001, 16'h8002, 16'hC003};
    logic [7:0] d[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int n, p;
    ioctl_download = 1'b1;
    rom_ready = 4'hF;
    tick();
    for (int i = 0; i < 4; i++) begin
      ioctl_addr = a[i];
      ioctl_dout = d[i];
      ioctl_wr = 1'b1;
      tick();
      ioctl_wr = 1'b0;
      checks++; if (rom_we !== 4'(1 << i)) begin errors++; $display("FAIL load_we%0d: got %b expected %b", i, rom_we, 4'(1 << i)); end
      checks++; if (rom_addr !== 14'(i) || rom_data !== d[i]) begin
        errors++; $display("FAIL load_ad%0d: got addr=%0h data=%0h expected addr=%0h data=%0h", i, rom_addr, rom_data, i, d[i]);
      end
      tick();
      checks++; if (rom_we !== 4'b0000) begin errors++; $display("FAIL load_we_drop%0d: got %b expected 0000", i, rom_we); end
    end
    ioctl_download = 1'b0;
    wait_run(n, p);
    checks++; if (n !== 18) begin errors++; $display("FAIL load_release: got %0d expected 18", n); end
    checks++; if (p !== 1) begin errors++; $display("FAIL load_done_pulses: got %0d expected 1", p); end
    checks++; if (byte_count !== 17'd4) begin errors++; $display("FAIL load_count: got %0d expected 4", byte_count); end
    checks++; if (checksum !== 8'hAA) begin errors++; $display("FAIL load_sum: got %0h expected aa", checksum); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL load_ovf: got %b expected 0", overflow); end
  endtask

  task automatic test_overflow();
    int n, p;
    ioctl_download = 1'b1;
    rom_ready = 4'b1110;
    tick();
    checks++; if (byte_count !== 17'd0 || checksum !== 8'h00) begin
      errors++; $display("FAIL ovf_clear: got cnt=%0d sum=%0h expected 0 0", byte_count, checksum);
    end
    ioctl_addr = 16'h0005;
    ioctl_dout = 8'h5A;
    ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    checks++; if (rom_we !== 4'b0001) begin errors++; $display("FAIL ovf_we: got %b expected 0001", rom_we); end
    tick();
    ioctl_addr = 16'h0006;
    ioctl_dout = 8'h77;
    ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    checks++; if (rom_we !== 4'b0001 || rom_addr !== 14'h5 || rom_data !== 8'h5A) begin
      errors++; $display("FAIL ovf_hold: got we=%b addr=%0h data=%0h expected 0001 5 5a", rom_we, rom_addr, rom_data);
    end
    repeat (2) tick();
    checks++; if (rom_we !== 4'b0001) begin errors++; $display("FAIL ovf_still: got %b expected 0001", rom_we); end
    rom_ready = 4'hF;
    tick();
    checks++; if (rom_we !== 4'b0000) begin errors++; $display("FAIL ovf_release: got %b expected 0000", rom_we); end
    checks++; if (byte_count !== 17'd1 || checksum !== 8'h5A) begin
      errors++; $display("FAIL ovf_count: got cnt=%0d sum=%0h expected 1 5a", byte_count, checksum);
    end
    ioctl_download = 1'b0;
    wait_run(n, p);
    checks++; if (p !== 1 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_done: got pulses=%0d ovf=%b expected 1 1", p, overflow);
    end
  endtask

  task automatic test_back_to_back();
    int n, p;
    logic [7:0] sum = 8'h00;
    logic [7:0] dv;
    ioctl_download = 1'b1;
    rom_ready = 4'hF;
    tick();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf_clear: got %b expected 0", overflow); end
    ioctl_wr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dv = 8'(8'h30 + i * 7);
      sum = sum + dv;
      ioctl_addr = {2'(i), 14'(i + 8)};
      ioctl_dout = dv;
      tick();
      checks++; if (rom_we !== 4'(1 << (i % 4)) || rom_data !== dv || rom_addr !== 14'(i + 8)) begin
        errors++; $display("FAIL b2b_%0d: got we=%b addr=%0h data=%0h expected %b %0h %0h",
                           i, rom_we, rom_addr, rom_data, 4'(1 << (i % 4)), i + 8, dv);
      end
    end
    ioctl_wr = 1'b0;
    tick();
    checks++; if (rom_we !== 4'b0000 || overflow !== 1'b0) begin
      errors++; $display("FAIL b2b_end: got we=%b ovf=%b expected 0000 0", rom_we, overflow);
    end
    checks++; if (byte_count !== 17'd6 || checksum !== sum) begin
      errors++; $display("FAIL b2b_count: got cnt=%0d sum=%0h expected 6 %0h", byte_count, checksum, sum);
    end
    ioctl_download = 1'b0;
    wait_run(n, p);
    checks++; if (n !== 18 || p !== 1) begin errors++; $display("FAIL b2b_release: got n=%0d pulses=%0d expected 18 1", n, p); end
  endtask

  task automatic test_reset_mid();
    int n, p;
    ioctl_download = 1'b1;
    rom_ready = 4'b0000;
    tick();
    ioctl_addr = 16'h8000;
    ioctl_dout = 8'hC3;
    ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    checks++; if (rom_we !== 4'b0100) begin errors++; $display("FAIL mid_we: got %b expected 0100", rom_we); end
    #2;
    reset = 1'b1;
    ioctl_download = 1'b0;
    #1;
    checks++; if (rom_we !== 4'b0000 || core_reset_n !== 1'b0 || byte_count !== 17'd0) begin
      errors++; $display("FAIL mid_async: got we=%b crn=%b cnt=%0d expected 0000 0 0", rom_we, core_reset_n, byte_count);
    end
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
    rom_ready = 4'hF;
    wait_run(n, p);
    checks++; if (n !== 16) begin errors++; $display("FAIL mid_hold_len: got %0d expected 16", n); end
    checks++; if (p !== 0) begin errors++; $display("FAIL mid_no_done: got %0d pulses expected 0", p); end
  endtask

  task automatic test_drain_stall();
    int n, p;
    ioctl_download = 1'b1;
    rom_ready = 4'b1011;
    tick();
    ioctl_addr = 16'h8007;
    ioctl_dout = 8'h99;
    ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    checks++; if (rom_we !== 4'b0100 || rom_addr !== 14'h7) begin
      errors++; $display("FAIL stall_we: got we=%b addr=%0h expected 0100 7", rom_we, rom_addr);
    end
    ioctl_download = 1'b0;
    repeat (10) tick();
    checks++; if (core_reset_n !== 1'b0 || rom_we !== 4'b0100) begin
      errors++; $display("FAIL stall_wait: got crn=%b we=%b expected 0 0100", core_reset_n, rom_we);
    end
    rom_ready = 4'hF;
    wait_run(n, p);
    checks++; if (n !== 18) begin errors++; $display("FAIL stall_release: got %0d expected 18", n); end
    checks++; if (p !== 1 || byte_count !== 17'd1 || checksum !== 8'h99) begin
      errors++; $display("FAIL stall_done: got pulses=%0d cnt=%0d sum=%0h expected 1 1 99", p, byte_count, checksum);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_drain_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
